// File: rtl/alu_op_scheduler.sv
// Two-requester scheduler around one registered 5-bit signed ALU (add, sub, shift-add mul, max).
// Define ALU_SCHED_RR_EN for round-robin on contention; otherwise req0 has fixed priority.
module alu_op_scheduler #(
    parameter int W = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    input  logic [1:0]     req0_sel,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    input  logic [1:0]     req1_sel,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [2*W-1:0] res_data,
    output logic           res_id,
    output logic           busy
);
    localparam int MUL_CYC = W;
    localparam int CW      = $clog2(MUL_CYC + 1);

    typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d;
    logic [1:0]       sel_q, sel_d;
    logic             id_q, id_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [2*W-1:0]   res_data_q, res_data_d;
    logic             res_id_q, res_id_d;
    logic             last_grant_q, last_grant_d;

    logic             any_valid, contested_grant, grant, accept;
    logic signed [W:0] ext_a, ext_b, sum, diff;
    logic [2*W-1:0]   alu_res, a_wide, partial, mul_next;
    logic             last_step;

    // Arbitration: a lone requester always wins; contention resolved by the build option.
    always_comb begin
        any_valid = req0_valid | req1_valid;
`ifdef ALU_SCHED_RR_EN
        contested_grant = ~last_grant_q;
`else
        contested_grant = 1'b0 & last_grant_q;
`endif
        if (req0_valid && req1_valid) grant = contested_grant;
        else                          grant = req1_valid;
        accept     = (state_q == IDLE) && any_valid;
        req0_ready = accept && !grant;
        req1_ready = accept && grant;
    end

    // Single-cycle ops are evaluated at W+1 bits, then sign-extended to the result width.
    always_comb begin
        ext_a = {a_q[W-1], a_q};
        ext_b = {b_q[W-1], b_q};
        sum   = ext_a + ext_b;
        diff  = ext_a - ext_b;
        case (sel_q)
            2'b00:   alu_res = {{(W-1){sum[W]}}, sum};
            2'b01:   alu_res = {{(W-1){diff[W]}}, diff};
            2'b11:   alu_res = ($signed(a_q) >= $signed(b_q)) ? {{W{a_q[W-1]}}, a_q}
                                                               : {{W{b_q[W-1]}}, b_q};
            default: alu_res = '0;
        endcase
    end

    // Shift-add multiply; the B sign bit carries negative weight, so its step subtracts.
    always_comb begin
        a_wide    = {{W{a_q[W-1]}}, a_q};
        partial   = a_wide << cnt_q;
        last_step = (cnt_q == CW'(MUL_CYC - 1));
        mul_next  = acc_q;
        if (b_q[cnt_q]) mul_next = last_step ? (acc_q - partial) : (acc_q + partial);
    end

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        sel_d        = sel_q;
        id_d         = id_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        res_data_d   = res_data_q;
        res_id_d     = res_id_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d          = grant ? req1_a   : req0_a;
                    b_d          = grant ? req1_b   : req0_b;
                    sel_d        = grant ? req1_sel : req0_sel;
                    id_d         = grant;
                    last_grant_d = grant;
                    cnt_d        = '0;
                    acc_d        = '0;
                    state_d      = (sel_d == 2'b10) ? MUL : EXEC;
                end
            end
            EXEC: begin
                res_data_d = alu_res;
                res_id_d   = id_q;
                state_d    = RESP;
            end
            MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + 1'b1;
                if (last_step) begin
                    res_data_d = mul_next;
                    res_id_d   = id_q;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            sel_q        <= '0;
            id_q         <= 1'b0;
            cnt_q        <= '0;
            acc_q        <= '0;
            res_data_q   <= '0;
            res_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sel_q        <= sel_d;
            id_q         <= id_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            res_data_q   <= res_data_d;
            res_id_q     <= res_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign res_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Self-checking bench for alu_op_scheduler: directed cases, random ops and contention,
// checked against an integer-arithmetic reference model.
module tb_alu_op_scheduler;
    localparam int W = 5;
`ifdef ALU_SCHED_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic           clk, rst_n;
    logic           req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic [1:0]     req0_sel, req1_sel;
    logic           res_valid, res_ready, res_id, busy;
    logic [2*W-1:0] res_data;

    int tests = 0;
    int fails = 0;
    int model_lg = 1;

    alu_op_scheduler #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] ref_res(input int a, input int b, input int sel);
        int r;
        case (sel)
            0:       r = a + b;
            1:       r = a - b;
            2:       r = a * b;
            default: r = (a >= b) ? a : b;
        endcase
        return r[9:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int id, input logic v, input int a, input int b, input int sel);
        if (id == 0) begin
            req0_valid = v; req0_a = a[W-1:0]; req0_b = b[W-1:0]; req0_sel = sel[1:0];
        end else begin
            req1_valid = v; req1_a = a[W-1:0]; req1_b = b[W-1:0]; req1_sel = sel[1:0];
        end
    endtask

    // One op from one requester: handshake, latency, result, optional back-pressure hold.
    task automatic run_op(input int id, input int a, input int b, input int sel, input int hold);
        logic [9:0] exp;
        int lat, waited;
        logic rdy;
        exp = ref_res(a, b, sel);
        lat = (sel == 2) ? W : 1;
        @(negedge clk);
        drive(id, 1'b1, a, b, sel);
        waited = 0;
        #1 rdy = (id == 0) ? req0_ready : req1_ready;
        while (!rdy && waited < 20) begin
            @(negedge clk);
            #1 rdy = (id == 0) ? req0_ready : req1_ready;
            waited++;
        end
        check("handshake_ready", 32'(rdy), 32'd1);
        @(negedge clk);
        drive(id, 1'b0, a, b, sel);
        model_lg = id;
        check("busy_after_accept", 32'(busy), 32'd1);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            check("res_valid_latency", 32'(res_valid), 32'(k == lat));
        end
        check("res_data", 32'(res_data), 32'(exp));
        check("res_id", 32'(res_id), 32'(id));
        for (int h = 0; h < hold; h++) begin
            drive(1 - id, 1'b1, 1, 1, 0);
            #1 check("no_accept_in_resp", 32'(req0_ready | req1_ready), 32'd0);
            @(negedge clk);
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_data", 32'(res_data), 32'(exp));
            check("hold_id", 32'(res_id), 32'(id));
        end
        drive(1 - id, 1'b0, 0, 0, 0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("consumed_valid", 32'(res_valid), 32'd0);
        check("consumed_busy", 32'(busy), 32'd0);
    endtask

    // Both requesters valid continuously with the sink always ready.
    task automatic contested(input int n);
        int got, cyc, exp_id;
        @(negedge clk);
        drive(0, 1'b1, 1, 2, 0);
        drive(1, 1'b1, 4, 1, 1);
        res_ready = 1'b1;
        got = 0;
        cyc = 0;
        while (got < n && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (req0_ready && req1_ready) check("ready_onehot", 32'd1, 32'd0);
            if (!RR && req1_ready) check("req1_ready_fixed", 32'(req1_ready), 32'd0);
            if (res_valid) begin
                exp_id = RR ? (1 - model_lg) : 0;
                check("contest_id", 32'(res_id), 32'(exp_id));
                check("contest_data", 32'(res_data), 32'(exp_id == 1 ? ref_res(4, 1, 1) : ref_res(1, 2, 0)));
                model_lg = exp_id;
                got++;
            end
        end
        check("contest_count", 32'(got), 32'(n));
        drive(0, 1'b0, 0, 0, 0);
        drive(1, 1'b0, 0, 0, 0);
        repeat (2) @(negedge clk);
        res_ready = 1'b0;
    endtask

    initial begin
        int ra, rb, rs, rid;
        rst_n = 1'b0;
        res_ready = 1'b0;
        drive(0, 1'b0, 0, 0, 0);
        drive(1, 1'b0, 0, 0, 0);
        #12;
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_res_id", 32'(res_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_lg = 1;

        contested(6);

        run_op(0, 7, 9, 0, 0);
        run_op(1, 3, 9, 1, 0);
        run_op(1, -16, 15, 1, 0);
        run_op(0, -16, -16, 2, 0);
        run_op(1, -16, 15, 2, 0);
        run_op(0, 15, 15, 2, 3);
        run_op(0, -3, 2, 3, 0);
        run_op(1, -3, -8, 3, 0);
        run_op(0, -1, -1, 3, 0);
        check("spec_sub_neg", 32'(ref_res(-16, 15, 1)), 32'h3E1);

        for (int i = 0; i < 24; i++) begin
            ra  = int'($urandom_range(0, 31)) - 16;
            rb  = int'($urandom_range(0, 31)) - 16;
            rs  = int'($urandom_range(0, 3));
            rid = int'($urandom_range(0, 1));
            run_op(rid, ra, rb, rs, int'($urandom_range(0, 2)));
        end

        // Reset in the middle of a multiply.
        @(negedge clk);
        drive(0, 1'b1, 5, 3, 2);
        #1 check("mul_rst_ready", 32'(req0_ready), 32'd1);
        @(negedge clk);
        drive(0, 1'b0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_res_valid", 32'(res_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_res_data", 32'(res_data), 32'd0);
        check("midrst_res_id", 32'(res_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_lg = 1;
        contested(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
